// File: rtl/pulse_generator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pulse_generator_pkg
// Description : Shared types and constants for the pulse generator family.
//               Holds the burst sequencer state encoding, the default
//               wait-state timeout and a small width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package pulse_generator_pkg;

    typedef enum logic [2:0] {
        SEQ_IDLE      = 3'd0,
        SEQ_ISSUE     = 3'd1,
        SEQ_WAIT_HIGH = 3'd2,
        SEQ_WAIT_LOW  = 3'd3,
        SEQ_GAP       = 3'd4
    } seq_state_t;

    localparam int SEQ_TIMEOUT_DEFAULT = 255;

    // Minimum number of bits needed to hold max_val (at least 1).
    function automatic int seq_cnt_width(input int max_val);
        int w;
        w = 1;
        while ((max_val >> w) != 0) begin
            w++;
        end
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pulse_seq_down_counter.sv
`default_nettype none
// ============================================================================
// Module      : pulse_seq_down_counter
// Description : Loadable down counter that stops at zero. Used by the burst
//               sequencer for both the inter-pulse gap and the wait timeout.
// Ports       : clk, reset    - clock, synchronous active-high reset
//               load_i        - load load_value_i (takes priority over en_i)
//               load_value_i  - value to load
//               en_i          - decrement by one while non-zero
//               zero_o        - counter currently holds zero
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_seq_down_counter
    import pulse_generator_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_value_i,
    input  logic             en_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_value_i;
        end else if (en_i && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/pulse_burst_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pulse_burst_sequencer
// Description : Turns one trigger into a burst of start strobes for a pulse
//               generator, waiting for each pulse to rise and fall and then a
//               programmable gap before the next strobe. Reports done,
//               timeout / ready-loss errors and ignored (overrun) triggers.
// Ports       : clk, reset     - clock, synchronous active-high reset
//               trigger_i      - burst request
//               burst_count_i  - pulses per burst (latched on accept)
//               gap_cycles_i   - idle cycles between fall and next start
//               gen_ready_i    - generator ready flag
//               gen_pulse_i    - generator pulse output
//               start_o        - one-cycle start strobe
//               busy_o         - sequencer not idle
//               done_o         - one-cycle burst-complete strobe
//               error_o        - one-cycle timeout / ready-loss strobe
//               overrun_o      - one-cycle ignored-trigger strobe
//               pulses_sent_o  - pulses completed in current/last burst
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_burst_sequencer
    import pulse_generator_pkg::*;
#(
    parameter int CNT_W          = 8,
    parameter int GAP_W          = 16,
    parameter int TIMEOUT_CYCLES = SEQ_TIMEOUT_DEFAULT   // must be >= 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             trigger_i,
    input  logic [CNT_W-1:0] burst_count_i,
    input  logic [GAP_W-1:0] gap_cycles_i,
    input  logic             gen_ready_i,
    input  logic             gen_pulse_i,
    output logic             start_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             error_o,
    output logic             overrun_o,
    output logic [CNT_W-1:0] pulses_sent_o
);

    // Timeout counter holds "remaining cycles minus one" so that reaching
    // zero while still waiting means TIMEOUT_CYCLES cycles have elapsed.
    localparam int              TO_W      = seq_cnt_width(TIMEOUT_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_RELOAD = TO_W'(TIMEOUT_CYCLES - 1);

    seq_state_t       state_q, state_d;
    logic             start_q, start_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic             overrun_q, overrun_d;
    logic             ovr_pend_q, ovr_pend_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] sent_q, sent_d;
    logic [GAP_W-1:0] gap_q, gap_d;

    logic             w_to_load, w_to_en, w_to_zero;
    logic             w_gap_load, w_gap_en, w_gap_zero;
    logic [CNT_W-1:0] w_sent_inc;
    logic             w_ovr_req;

    assign w_sent_inc = sent_q + CNT_W'(1);

    pulse_seq_down_counter #(.WIDTH(TO_W)) u_timeout_cnt (
        .clk          (clk),
        .reset        (reset),
        .load_i       (w_to_load),
        .load_value_i (TO_RELOAD),
        .en_i         (w_to_en),
        .zero_o       (w_to_zero)
    );

    pulse_seq_down_counter #(.WIDTH(GAP_W)) u_gap_cnt (
        .clk          (clk),
        .reset        (reset),
        .load_i       (w_gap_load),
        .load_value_i (gap_q - GAP_W'(1)),
        .en_i         (w_gap_en),
        .zero_o       (w_gap_zero)
    );

    always_comb begin
        state_d    = state_q;
        done_d     = 1'b0;
        error_d    = 1'b0;
        count_d    = count_q;
        gap_d      = gap_q;
        sent_d     = sent_q;
        w_to_load  = 1'b0;
        w_to_en    = 1'b0;
        w_gap_load = 1'b0;
        w_gap_en   = 1'b0;

        case (state_q)
            SEQ_IDLE: begin
                // Triggers without a ready generator or with a zero count
                // are dropped without any strobe.
                if (trigger_i && gen_ready_i && (burst_count_i != '0)) begin
                    count_d = burst_count_i;
                    gap_d   = gap_cycles_i;
                    sent_d  = '0;
                    state_d = SEQ_ISSUE;
                end
            end
            SEQ_ISSUE: begin
                w_to_load = 1'b1;
                state_d   = SEQ_WAIT_HIGH;
            end
            SEQ_WAIT_HIGH: begin
                if (gen_pulse_i) begin
                    w_to_load = 1'b1;
                    state_d   = SEQ_WAIT_LOW;
                end else if (w_to_zero) begin
                    error_d = 1'b1;
                    state_d = SEQ_IDLE;
                end else begin
                    w_to_en = 1'b1;
                end
            end
            SEQ_WAIT_LOW: begin
                if (!gen_pulse_i) begin
                    sent_d = w_sent_inc;
                    if (w_sent_inc == count_q) begin
                        done_d  = 1'b1;
                        state_d = SEQ_IDLE;
                    end else if (gap_q == '0) begin
                        state_d = SEQ_ISSUE;
                    end else begin
                        w_gap_load = 1'b1;
                        state_d    = SEQ_GAP;
                    end
                end else if (w_to_zero) begin
                    error_d = 1'b1;
                    state_d = SEQ_IDLE;
                end else begin
                    w_to_en = 1'b1;
                end
            end
            SEQ_GAP: begin
                if (w_gap_zero) begin
                    state_d = SEQ_ISSUE;
                end else begin
                    w_gap_en = 1'b1;
                end
            end
            default: begin
                state_d = SEQ_IDLE;
            end
        endcase

        // Losing the generator aborts the burst and wins over any transition
        // decided above, including a pulse completion seen this same cycle.
        if ((state_q != SEQ_IDLE) && !gen_ready_i) begin
            state_d = SEQ_IDLE;
            error_d = 1'b1;
            done_d  = 1'b0;
            sent_d  = sent_q;
        end
    end

    always_comb begin
        start_d = (state_d == SEQ_ISSUE);
        busy_d  = (state_d != SEQ_IDLE);

        // An overrun request that would coincide with a start strobe is held
        // for one cycle; the cycle after ISSUE never carries a strobe.
        w_ovr_req = (busy_q && trigger_i) || ovr_pend_q;
        if (start_d) begin
            overrun_d  = 1'b0;
            ovr_pend_d = w_ovr_req;
        end else begin
            overrun_d  = w_ovr_req;
            ovr_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= SEQ_IDLE;
            start_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            overrun_q  <= 1'b0;
            ovr_pend_q <= 1'b0;
            count_q    <= '0;
            sent_q     <= '0;
            gap_q      <= '0;
        end else begin
            state_q    <= state_d;
            start_q    <= start_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            overrun_q  <= overrun_d;
            ovr_pend_q <= ovr_pend_d;
            count_q    <= count_d;
            sent_q     <= sent_d;
            gap_q      <= gap_d;
        end
    end

    assign start_o       = start_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign error_o       = error_q;
    assign overrun_o     = overrun_q;
    assign pulses_sent_o = sent_q;

endmodule
`default_nettype wire

// File: tb/tb_pulse_burst_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pulse_burst_sequencer
// Description : Self-checking bench for pulse_burst_sequencer. A behavioural
//               generator answers each start strobe with a pulse after a
//               programmable delay and width; expected strobe cycles come
//               from a timeline model of the burst.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pulse_burst_sequencer;

    localparam int TO = 10;

    logic       clk;
    logic       reset;
    logic       trigger_i;
    logic [7:0] burst_count_i;
    logic [15:0] gap_cycles_i;
    logic       gen_ready_i;
    logic       gen_pulse_i;
    logic       start_o, busy_o, done_o, error_o, overrun_o;
    logic [7:0] pulses_sent_o;

    int n_cmp, n_fail;
    int cyc;
    int obs_start[$], obs_done[$], obs_err[$], obs_ovr[$];
    int busy_cnt, coinc_cnt;
    bit gen_en;
    int gen_d, gen_w;

    pulse_burst_sequencer #(
        .CNT_W          (8),
        .GAP_W          (16),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .trigger_i     (trigger_i),
        .burst_count_i (burst_count_i),
        .gap_cycles_i  (gap_cycles_i),
        .gen_ready_i   (gen_ready_i),
        .gen_pulse_i   (gen_pulse_i),
        .start_o       (start_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .error_o       (error_o),
        .overrun_o     (overrun_o),
        .pulses_sent_o (pulses_sent_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter and event log, sampled 1 time unit after each edge.
    initial begin
        cyc = 0; busy_cnt = 0; coinc_cnt = 0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (start_o)   obs_start.push_back(cyc);
            if (done_o)    obs_done.push_back(cyc);
            if (error_o)   obs_err.push_back(cyc);
            if (overrun_o) obs_ovr.push_back(cyc);
            if (busy_o)    busy_cnt++;
            if (start_o && (done_o || error_o || overrun_o)) coinc_cnt++;
        end
    end

    // Behavioural pulse generator: a start seen in cycle k gives a pulse
    // high during cycles k+gen_d .. k+gen_d+gen_w-1.
    initial begin
        int hi_from, hi_to;
        hi_from = -1; hi_to = -2;
        gen_pulse_i = 1'b0;
        forever begin
            @(negedge clk);
            if (start_o && gen_en) begin
                hi_from = cyc + gen_d;
                hi_to   = cyc + gen_d + gen_w - 1;
            end
            gen_pulse_i = gen_en && (cyc >= hi_from) && (cyc <= hi_to);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Timeline model: each pulse occupies issue + delay + width + fall
    // detection + gap cycles before the next start.
    function automatic int exp_start(int s1, int i, int d, int w, int g);
        return s1 + i * (d + w + 1 + g);
    endfunction

    function automatic int exp_done(int s1, int n, int d, int w, int g);
        return exp_start(s1, n - 1, d, w, g) + d + w + 1;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic launch(input int n, input int g, input int d, input int w,
                          input bit en, output int s1);
        @(negedge clk);
        burst_count_i = 8'(n);
        gap_cycles_i  = 16'(g);
        gen_d = d; gen_w = w; gen_en = en;
        obs_start.delete(); obs_done.delete(); obs_err.delete(); obs_ovr.delete();
        busy_cnt  = 0;
        trigger_i = 1'b1;
        s1 = cyc + 1;
        @(negedge clk);
        trigger_i = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (!busy_o) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({start_o, busy_o, done_o, error_o, overrun_o, pulses_sent_o} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want all zero",
                     {start_o, busy_o, done_o, error_o, overrun_o, pulses_sent_o});
        end
        reset = 1'b0;
        idle(2);
    endtask

    task automatic test_directed_bursts();
        int tn[2] = '{3, 2};
        int tg[2] = '{4, 0};
        int s1;
        bit ok;
        for (int k = 0; k < 2; k++) begin
            launch(tn[k], tg[k], 2, 3, 1'b1, s1);
            wait_idle(400, ok);
            n_cmp++;
            if (!ok) begin n_fail++; $display("FAIL dir%0d_idle: busy still %b", k, busy_o); end
            n_cmp++;
            if (obs_start.size() != tn[k]) begin
                n_fail++; $display("FAIL dir%0d_starts: got %0d want %0d", k, obs_start.size(), tn[k]);
            end else begin
                for (int i = 0; i < tn[k]; i++) begin
                    n_cmp++;
                    if (obs_start[i] != exp_start(s1, i, 2, 3, tg[k])) begin
                        n_fail++;
                        $display("FAIL dir%0d_start%0d_cycle: got %0d want %0d", k, i,
                                 obs_start[i], exp_start(s1, i, 2, 3, tg[k]));
                    end
                end
            end
            n_cmp++;
            if (obs_done.size() != 1 || obs_done[0] != exp_done(s1, tn[k], 2, 3, tg[k])) begin
                n_fail++;
                $display("FAIL dir%0d_done: got %0d strobes want 1 at cycle %0d", k,
                         obs_done.size(), exp_done(s1, tn[k], 2, 3, tg[k]));
            end
            n_cmp++;
            if (pulses_sent_o !== 8'(tn[k])) begin
                n_fail++; $display("FAIL dir%0d_pulses_sent: got %0d want %0d", k, pulses_sent_o, tn[k]);
            end
            n_cmp++;
            if (busy_cnt != exp_done(s1, tn[k], 2, 3, tg[k]) - s1 || obs_err.size() != 0) begin
                n_fail++; $display("FAIL dir%0d_busy_err: busy %0d err %0d want %0d/0", k,
                                   busy_cnt, obs_err.size(), exp_done(s1, tn[k], 2, 3, tg[k]) - s1);
            end
            idle(12);
        end
    endtask

    task automatic test_ignored();
        @(negedge clk);
        obs_start.delete(); obs_done.delete(); obs_err.delete(); obs_ovr.delete();
        busy_cnt = 0;
        gen_ready_i = 1'b0; burst_count_i = 8'd3; trigger_i = 1'b1;
        idle(3);
        gen_ready_i = 1'b1; burst_count_i = 8'd0;
        idle(3);
        trigger_i = 1'b0;
        idle(3);
        n_cmp++;
        if (obs_start.size() != 0 || busy_cnt != 0) begin
            n_fail++; $display("FAIL ignored_activity: starts %0d busy %0d want 0/0", obs_start.size(), busy_cnt);
        end
        n_cmp++;
        if (obs_done.size() + obs_err.size() + obs_ovr.size() != 0) begin
            n_fail++; $display("FAIL ignored_strobes: got %0d want 0",
                               obs_done.size() + obs_err.size() + obs_ovr.size());
        end
    endtask

    task automatic test_timeout();
        int s1;
        bit ok;
        launch(1, 0, 1, 1, 1'b0, s1);
        wait_idle(100, ok);
        n_cmp++;
        if (!ok || obs_err.size() != 1 || obs_err[0] != s1 + TO + 1) begin
            n_fail++; $display("FAIL timeout_error: got %0d strobes want 1 at cycle %0d", obs_err.size(), s1 + TO + 1);
        end
        n_cmp++;
        if (obs_done.size() != 0 || busy_o !== 1'b0 || busy_cnt != TO + 1) begin
            n_fail++; $display("FAIL timeout_state: done %0d busy %b busycyc %0d want 0/0/%0d",
                               obs_done.size(), busy_o, busy_cnt, TO + 1);
        end
        idle(4);
    endtask

    task automatic test_reset_mid();
        int s1;
        launch(3, 2, 2, 2, 1'b1, s1);
        idle(8);
        n_cmp++;
        if (busy_o !== 1'b1 || pulses_sent_o !== 8'd1) begin
            n_fail++; $display("FAIL midreset_pre: busy %b sent %0d want 1/1", busy_o, pulses_sent_o);
        end
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({start_o, busy_o, done_o, error_o, overrun_o, pulses_sent_o} !== 13'd0) begin
            n_fail++; $display("FAIL midreset_outputs: got %b want all zero",
                               {start_o, busy_o, done_o, error_o, overrun_o, pulses_sent_o});
        end
        @(negedge clk);
        reset = 1'b0;
        idle(15);
        n_cmp++;
        if (obs_done.size() != 0 || obs_err.size() != 0) begin
            n_fail++; $display("FAIL midreset_strobes: done %0d err %0d want 0/0", obs_done.size(), obs_err.size());
        end
    endtask

    task automatic test_ready_drop();
        int s1, c;
        launch(3, 2, 2, 2, 1'b1, s1);
        idle(4);
        gen_ready_i = 1'b0;
        c = cyc;
        @(negedge clk);
        gen_ready_i = 1'b1;
        n_cmp++;
        if (error_o !== 1'b1 || busy_o !== 1'b0) begin
            n_fail++; $display("FAIL ready_drop_now: error %b busy %b want 1/0", error_o, busy_o);
        end
        idle(12);
        n_cmp++;
        if (obs_err.size() != 1 || obs_err[0] != c + 1 || obs_done.size() != 0) begin
            n_fail++; $display("FAIL ready_drop_log: err %0d done %0d want 1 at %0d / 0",
                               obs_err.size(), obs_done.size(), c + 1);
        end
    endtask

    task automatic test_overrun();
        int s1, c;
        bit ok;
        launch(2, 3, 3, 2, 1'b1, s1);
        trigger_i = 1'b1;
        burst_count_i = 8'd5;
        c = cyc;
        @(negedge clk);
        trigger_i = 1'b0;
        wait_idle(200, ok);
        n_cmp++;
        if (obs_ovr.size() != 1 || obs_ovr[0] != c + 1) begin
            n_fail++; $display("FAIL overrun_strobe: got %0d strobes want 1 at cycle %0d", obs_ovr.size(), c + 1);
        end
        n_cmp++;
        if (!ok || obs_start.size() != 2 || pulses_sent_o !== 8'd2) begin
            n_fail++; $display("FAIL overrun_burst: starts %0d sent %0d want 2/2", obs_start.size(), pulses_sent_o);
        end
        n_cmp++;
        if (obs_done.size() != 1 || obs_done[0] != exp_done(s1, 2, 3, 2, 3)) begin
            n_fail++; $display("FAIL overrun_done: got %0d strobes want 1 at %0d", obs_done.size(), exp_done(s1, 2, 3, 2, 3));
        end
        idle(12);
    endtask

    task automatic test_back_to_back();
        int s1, b;
        bit ok, seen;
        launch(2, 1, 1, 1, 1'b1, s1);
        seen = 1'b0; b = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (done_o) begin
                seen = 1'b1;
                b = cyc;
                burst_count_i = 8'd1; gap_cycles_i = 16'd0; gen_d = 2; gen_w = 2;
                trigger_i = 1'b1;
            end
            @(negedge clk);
        end
        trigger_i = 1'b0;
        wait_idle(100, ok);
        n_cmp++;
        if (!seen || b != exp_done(s1, 2, 1, 1, 1)) begin
            n_fail++; $display("FAIL b2b_first_done: got cycle %0d want %0d", b, exp_done(s1, 2, 1, 1, 1));
        end
        n_cmp++;
        if (obs_start.size() != 3 || obs_start[obs_start.size() - 1] != b + 1) begin
            n_fail++; $display("FAIL b2b_restart: starts %0d want 3, last at %0d", obs_start.size(), b + 1);
        end
        n_cmp++;
        if (!ok || obs_done.size() != 2 || obs_ovr.size() != 0 || pulses_sent_o !== 8'd1) begin
            n_fail++; $display("FAIL b2b_second: done %0d ovr %0d sent %0d want 2/0/1",
                               obs_done.size(), obs_ovr.size(), pulses_sent_o);
        end
        idle(12);
    endtask

    task automatic test_random_bursts();
        int n, g, d, w, s1;
        bit ok;
        for (int it = 0; it < 10; it++) begin
            n = $urandom_range(1, 4);
            g = $urandom_range(0, 5);
            d = $urandom_range(1, 4);
            w = $urandom_range(1, 4);
            launch(n, g, d, w, 1'b1, s1);
            wait_idle(400, ok);
            n_cmp++;
            if (!ok || obs_start.size() != n) begin
                n_fail++; $display("FAIL rnd%0d_starts: got %0d want %0d (n%0d g%0d d%0d w%0d)",
                                   it, obs_start.size(), n, n, g, d, w);
            end else begin
                for (int i = 0; i < n; i++) begin
                    n_cmp++;
                    if (obs_start[i] != exp_start(s1, i, d, w, g)) begin
                        n_fail++; $display("FAIL rnd%0d_start%0d: got %0d want %0d", it, i,
                                           obs_start[i], exp_start(s1, i, d, w, g));
                    end
                end
            end
            n_cmp++;
            if (obs_done.size() != 1 || obs_done[0] != exp_done(s1, n, d, w, g) || obs_err.size() != 0) begin
                n_fail++; $display("FAIL rnd%0d_done: done %0d err %0d want 1 at %0d / 0", it,
                                   obs_done.size(), obs_err.size(), exp_done(s1, n, d, w, g));
            end
            n_cmp++;
            if (pulses_sent_o !== 8'(n)) begin
                n_fail++; $display("FAIL rnd%0d_pulses_sent: got %0d want %0d", it, pulses_sent_o, n);
            end
            idle(12);
        end
    endtask

    task automatic test_invariants();
        n_cmp++;
        if (coinc_cnt != 0) begin
            n_fail++; $display("FAIL strobe_exclusive: got %0d coincident cycles want 0", coinc_cnt);
        end
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        reset = 1'b1; trigger_i = 1'b0; burst_count_i = '0; gap_cycles_i = '0;
        gen_ready_i = 1'b1; gen_en = 1'b0; gen_d = 1; gen_w = 1;
        test_reset();
        test_directed_bursts();
        test_ignored();
        test_timeout();
        test_reset_mid();
        test_ready_drop();
        test_overrun();
        test_back_to_back();
        test_random_bursts();
        test_invariants();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
